// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is dropped
// and a pop from an empty FIFO is ignored, so callers may drive push/pop freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally; count tracks simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are shifted
// out LSB-first at CLKS_PER_BIT clocks per bit on a registered, idle-high line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_tx_state_t    state_r;
  uart_tx_state_t    state_nxt_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic [7:0]        shift_nxt_s;
  logic              tx_r;
  logic              tx_nxt_s;
  logic              baud_last_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [7:0]        fifo_rdata_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  assign wr_ready    = !fifo_full_s;
  assign push_s      = wr_en && wr_ready;
  assign baud_last_s = (baud_cnt_r == BAUD_LAST);
  assign busy        = (state_r != IDLE) || !fifo_empty_s;
  assign tx          = tx_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: end of stop bit chains straight into the next start bit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (!fifo_empty_s) state_nxt_s = START; else state_nxt_s = IDLE;
      START:   if (baud_last_s) state_nxt_s = DATA; else state_nxt_s = START;
      DATA:    if (baud_last_s && (bit_idx_r == LAST_BIT)) state_nxt_s = STOP;
               else state_nxt_s = DATA;
      STOP:    if (baud_last_s) state_nxt_s = fifo_empty_s ? IDLE : START;
               else state_nxt_s = STOP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs: tx is precomputed from the next state so the flop holds the line value.
  always_comb begin
    pop_s       = 1'b0;
    shift_nxt_s = shift_r;
    tx_nxt_s    = 1'b1;
    if (((state_r == IDLE) || ((state_r == STOP) && baud_last_s)) && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (pop_s) begin
      shift_nxt_s = fifo_rdata_s;
    end else if ((state_r == DATA) && baud_last_s) begin
      shift_nxt_s = {1'b0, shift_r[7:1]};
    end else begin
      shift_nxt_s = shift_r;
    end
    case (state_nxt_s)
      IDLE:    tx_nxt_s = 1'b1;
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = shift_nxt_s[0];
      STOP:    tx_nxt_s = 1'b1;
      default: tx_nxt_s = 1'b1;
    endcase
  end

  // Baud counter, bit index, shift register and tx flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
    end else begin
      shift_r <= shift_nxt_s;
      tx_r    <= tx_nxt_s;
      if (pop_s || (state_r == IDLE) || baud_last_s) begin
        baud_cnt_r <= {BAUD_W{1'b0}};
      end else begin
        baud_cnt_r <= baud_cnt_r + 1'b1;
      end
      if (pop_s) begin
        bit_idx_r <= 3'd0;
      end else if ((state_r == DATA) && baud_last_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
    end
  end

endmodule
